bullet_pool: RTL and testbench

//  Parametrised bullet slot pool: one instance per owner (player or enemies).

---
 rtl/bullet_pool.sv | 186 ++++++++++++++++++
 tb/tb_bullet_pool.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bullet_pool.sv
// Bullet slot pool: lowest-free spawn, per-tick vertical move, retire at bounds or on kill/clear.
// All outputs registered (1-cycle latency); optional o_DropCnt when BULLET_POOL_DROPCNT_EN is defined.
module bullet_pool #(
  parameter int N_SLOT   = 16,
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int STEP     = 1,
  parameter int DIR_DOWN = 0,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 479
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst,
  input  logic                           i_Tick,
  input  logic                           i_Clear,
  input  logic                           i_SpawnReq,
  input  logic [X_W+Y_W-1:0]             i_SpawnPos,
  input  logic [N_SLOT-1:0]              i_KillMask,
  output logic                           o_SpawnAck,
  output logic                           o_SpawnDrop,
  output logic [N_SLOT-1:0]              o_Alive,
  output logic [N_SLOT*(X_W+Y_W)-1:0]    o_PosFlat,
  output logic [$clog2(N_SLOT+1)-1:0]    o_Count,
  output logic                           o_Full,
  output logic                           o_Empty
`ifdef BULLET_POOL_DROPCNT_EN
  ,
  output logic [15:0]                    o_DropCnt
`endif
);

  localparam int PW = X_W + Y_W;
  localparam int CW = $clog2(N_SLOT + 1);

  // Y comparisons run one bit wider so Y+STEP can never wrap.
  localparam logic [Y_W:0]    C_ONE   = (Y_W+1)'(1);
  localparam logic [Y_W:0]    C_STEP  = (Y_W+1)'(STEP);
  localparam logic [Y_W:0]    C_YMAX  = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W:0]    C_YLO   = (Y_W+1)'(Y_MIN + STEP);
  localparam logic [Y_W:0]    C_YMIN1 = (Y_W+1)'(Y_MIN + 1);
  localparam logic [PW-1:0]   C_DEAD  = '1;
  localparam logic [CW-1:0]   C_FULL  = CW'(N_SLOT);

  logic [N_SLOT-1:0] r_Alive;
  logic [PW-1:0]     r_Pos [N_SLOT];
  logic              r_Ack;
  logic              r_Drop;
  logic [CW-1:0]     r_Count;
  logic              r_Full;
  logic              r_Empty;

  logic [N_SLOT-1:0] w_alive_nxt;
  logic [PW-1:0]     w_pos_nxt [N_SLOT];
  logic [N_SLOT-1:0] w_spawn_oh;
  logic              w_free;
  logic [Y_W:0]      w_sy_ext;
  logic              w_sy_ok;
  logic              w_spawn_ok;
  logic              w_drop;
  logic [Y_W:0]      w_yext;
  logic [CW-1:0]     w_cnt_nxt;

  // Free slot is chosen from the pre-kill alive mask, so a slot freed this edge waits a cycle.
  always_comb begin
    w_spawn_oh = '0;
    w_free     = 1'b0;
    for (int k = 0; k < N_SLOT; k++) begin
      if (!r_Alive[k] && !w_free) begin
        w_spawn_oh[k] = 1'b1;
        w_free        = 1'b1;
      end
    end
  end

  assign w_sy_ext   = {1'b0, i_SpawnPos[Y_W-1:0]};
  assign w_sy_ok    = ((w_sy_ext + C_ONE) >= C_YMIN1) && (w_sy_ext <= C_YMAX);
  assign w_spawn_ok = i_SpawnReq && w_free && w_sy_ok && !i_Clear;
  assign w_drop     = i_SpawnReq && !w_spawn_ok;

  always_comb begin
    w_alive_nxt = r_Alive;
    w_yext      = '0;
    for (int k = 0; k < N_SLOT; k++) begin
      w_pos_nxt[k] = r_Pos[k];
    end
    if (i_Clear) begin
      w_alive_nxt = '0;
      for (int k = 0; k < N_SLOT; k++) begin
        w_pos_nxt[k] = C_DEAD;
      end
    end else begin
      for (int k = 0; k < N_SLOT; k++) begin
        w_yext = {1'b0, r_Pos[k][Y_W-1:0]};
        if (r_Alive[k]) begin
          if (i_KillMask[k]) begin
            w_alive_nxt[k] = 1'b0;
            w_pos_nxt[k]   = C_DEAD;
          end else if (i_Tick) begin
            if (DIR_DOWN != 0) begin
              if ((w_yext + C_STEP) > C_YMAX) begin
                w_alive_nxt[k] = 1'b0;
                w_pos_nxt[k]   = C_DEAD;
              end else begin
                w_pos_nxt[k][Y_W-1:0] = Y_W'(w_yext + C_STEP);
              end
            end else begin
              if (w_yext < C_YLO) begin
                w_alive_nxt[k] = 1'b0;
                w_pos_nxt[k]   = C_DEAD;
              end else begin
                w_pos_nxt[k][Y_W-1:0] = Y_W'(w_yext - C_STEP);
              end
            end
          end
        end else if (w_spawn_ok && w_spawn_oh[k]) begin
          // Spawned slot takes the request position untouched by a coincident tick.
          w_alive_nxt[k] = 1'b1;
          w_pos_nxt[k]   = i_SpawnPos;
        end
      end
    end
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int k = 0; k < N_SLOT; k++) begin
      w_cnt_nxt = w_cnt_nxt + CW'(w_alive_nxt[k]);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_Alive <= '0;
      for (int k = 0; k < N_SLOT; k++) begin
        r_Pos[k] <= C_DEAD;
      end
      r_Ack   <= 1'b0;
      r_Drop  <= 1'b0;
      r_Count <= '0;
      r_Full  <= 1'b0;
      r_Empty <= 1'b1;
    end else begin
      r_Alive <= w_alive_nxt;
      for (int k = 0; k < N_SLOT; k++) begin
        r_Pos[k] <= w_pos_nxt[k];
      end
      r_Ack   <= w_spawn_ok;
      r_Drop  <= w_drop;
      r_Count <= w_cnt_nxt;
      r_Full  <= (w_cnt_nxt == C_FULL);
      r_Empty <= (w_cnt_nxt == '0);
    end
  end

`ifdef BULLET_POOL_DROPCNT_EN
  logic [15:0] r_DropCnt;

  // A request dropped by i_Clear still shows as o_SpawnDrop afterwards, so it seeds the count.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_DropCnt <= '0;
    end else if (i_Clear) begin
      r_DropCnt <= {15'd0, w_drop};
    end else if (w_drop && (r_DropCnt != 16'hFFFF)) begin
      r_DropCnt <= r_DropCnt + 16'd1;
    end
  end

  assign o_DropCnt = r_DropCnt;
`endif

  always_comb begin
    o_PosFlat = '0;
    for (int k = 0; k < N_SLOT; k++) begin
      o_PosFlat[k*PW +: PW] = r_Pos[k];
    end
  end

  assign o_Alive     = r_Alive;
  assign o_SpawnAck  = r_Ack;
  assign o_SpawnDrop = r_Drop;
  assign o_Count     = r_Count;
  assign o_Full      = r_Full;
  assign o_Empty     = r_Empty;

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool with default parameters (16 slots, upward-moving, STEP=1).
module tb_bullet_pool;

  logic         i_Clk = 1'b0;
  logic         i_Rst;
  logic         i_Tick;
  logic         i_Clear;
  logic         i_SpawnReq;
  logic [18:0]  i_SpawnPos;
  logic [15:0]  i_KillMask;
  logic         o_SpawnAck;
  logic         o_SpawnDrop;
  logic [15:0]  o_Alive;
  logic [303:0] o_PosFlat;
  logic [4:0]   o_Count;
  logic         o_Full;
  logic         o_Empty;
`ifdef BULLET_POOL_DROPCNT_EN
  logic [15:0]  o_DropCnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  bullet_pool dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Tick     (i_Tick),
    .i_Clear    (i_Clear),
    .i_SpawnReq (i_SpawnReq),
    .i_SpawnPos (i_SpawnPos),
    .i_KillMask (i_KillMask),
    .o_SpawnAck (o_SpawnAck),
    .o_SpawnDrop(o_SpawnDrop),
    .o_Alive    (o_Alive),
    .o_PosFlat  (o_PosFlat),
    .o_Count    (o_Count),
    .o_Full     (o_Full),
`ifdef BULLET_POOL_DROPCNT_EN
    .o_Empty    (o_Empty),
    .o_DropCnt  (o_DropCnt)
`else
    .o_Empty    (o_Empty)
`endif
  );

  always #5 i_Clk = ~i_Clk;

  function automatic logic [18:0] slot(input int k);
    return o_PosFlat[k*19 +: 19];
  endfunction

  task automatic cyc();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic spawn(input logic [9:0] x, input logic [8:0] y);
    i_SpawnReq = 1'b1;
    i_SpawnPos = {x, y};
    cyc();
    i_SpawnReq = 1'b0;
  endtask

  task automatic do_clear();
    i_Clear = 1'b1;
    cyc();
    i_Clear = 1'b0;
  endtask

  task automatic test_reset();
    i_Rst = 1'b0; i_Tick = 1'b0; i_Clear = 1'b0; i_SpawnReq = 1'b0;
    i_SpawnPos = '0; i_KillMask = '0;
    cyc(); cyc();
    n_total++; if (o_Alive !== 16'h0000) $display("FAIL rst_alive got %h exp 0000", o_Alive); else n_pass++;
    n_total++; if (o_Count !== 5'd0) $display("FAIL rst_count got %0d exp 0", o_Count); else n_pass++;
    n_total++; if (o_Empty !== 1'b1 || o_Full !== 1'b0) $display("FAIL rst_flags got e=%b f=%b exp e=1 f=0", o_Empty, o_Full); else n_pass++;
    n_total++; if (o_SpawnAck !== 1'b0 || o_SpawnDrop !== 1'b0) $display("FAIL rst_ackdrop got %b%b exp 00", o_SpawnAck, o_SpawnDrop); else n_pass++;
    n_total++; if (slot(7) !== 19'h7FFFF) $display("FAIL rst_pos got %h exp 7ffff", slot(7)); else n_pass++;
    i_Rst = 1'b1;
    cyc();
  endtask

  task automatic test_spawn3();
    for (int i = 0; i < 3; i++) begin
      spawn(10'd100, 9'd200);
      n_total++; if (o_SpawnAck !== 1'b1 || o_SpawnDrop !== 1'b0) $display("FAIL spawn3_ack%0d got %b%b exp 10", i, o_SpawnAck, o_SpawnDrop); else n_pass++;
    end
    n_total++; if (o_Alive !== 16'h0007) $display("FAIL spawn3_alive got %h exp 0007", o_Alive); else n_pass++;
    n_total++; if (o_Count !== 5'd3 || o_Empty !== 1'b0) $display("FAIL spawn3_count got %0d e=%b exp 3 e=0", o_Count, o_Empty); else n_pass++;
    n_total++; if (slot(1) !== {10'd100, 9'd200}) $display("FAIL spawn3_pos got %h exp %h", slot(1), {10'd100, 9'd200}); else n_pass++;
    cyc();
    n_total++; if (o_SpawnAck !== 1'b0) $display("FAIL spawn3_pulse got %b exp 0", o_SpawnAck); else n_pass++;
  endtask

  task automatic test_move_retire();
    do_clear();
    spawn(10'd5, 9'd1);
    i_Tick = 1'b1; cyc(); i_Tick = 1'b0;
    n_total++; if (slot(0) !== {10'd5, 9'd0} || o_Alive[0] !== 1'b1) $display("FAIL move_y0 got %h a=%b exp %h a=1", slot(0), o_Alive[0], {10'd5, 9'd0}); else n_pass++;
    i_Tick = 1'b1; cyc(); i_Tick = 1'b0;
    n_total++; if (o_Alive !== 16'h0000 || o_Count !== 5'd0) $display("FAIL retire_alive got %h c=%0d exp 0000 c=0", o_Alive, o_Count); else n_pass++;
    n_total++; if (slot(0) !== 19'h7FFFF) $display("FAIL retire_pos got %h exp 7ffff", slot(0)); else n_pass++;
  endtask

  task automatic test_full();
    do_clear();
    for (int i = 0; i < 16; i++) spawn(10'(i), 9'd300);
    n_total++; if (o_Full !== 1'b1 || o_Count !== 5'd16) $display("FAIL full_flag got f=%b c=%0d exp f=1 c=16", o_Full, o_Count); else n_pass++;
    n_total++; if (slot(15) !== {10'd15, 9'd300}) $display("FAIL full_pos15 got %h exp %h", slot(15), {10'd15, 9'd300}); else n_pass++;
    spawn(10'd99, 9'd300);
    n_total++; if (o_SpawnDrop !== 1'b1 || o_SpawnAck !== 1'b0) $display("FAIL full_drop got ack=%b drop=%b exp ack=0 drop=1", o_SpawnAck, o_SpawnDrop); else n_pass++;
    n_total++; if (o_Alive !== 16'hFFFF || o_Full !== 1'b1) $display("FAIL full_state got %h f=%b exp ffff f=1", o_Alive, o_Full); else n_pass++;
  endtask

  task automatic test_kill_spawn();
    i_KillMask = 16'h0004;
    spawn(10'd7, 9'd250);
    i_KillMask = '0;
    n_total++; if (o_SpawnDrop !== 1'b1 || o_SpawnAck !== 1'b0) $display("FAIL kill_drop got ack=%b drop=%b exp ack=0 drop=1", o_SpawnAck, o_SpawnDrop); else n_pass++;
    n_total++; if (o_Alive !== 16'hFFFB || o_Count !== 5'd15 || o_Full !== 1'b0) $display("FAIL kill_alive got %h c=%0d f=%b exp fffb c=15 f=0", o_Alive, o_Count, o_Full); else n_pass++;
    n_total++; if (slot(2) !== 19'h7FFFF) $display("FAIL kill_pos got %h exp 7ffff", slot(2)); else n_pass++;
    spawn(10'd7, 9'd250);
    n_total++; if (o_SpawnAck !== 1'b1 || o_Alive !== 16'hFFFF) $display("FAIL kill_reuse got ack=%b alive=%h exp ack=1 alive=ffff", o_SpawnAck, o_Alive); else n_pass++;
    n_total++; if (slot(2) !== {10'd7, 9'd250}) $display("FAIL kill_reuse_pos got %h exp %h", slot(2), {10'd7, 9'd250}); else n_pass++;
  endtask

  task automatic test_spawn_tick();
    do_clear();
    spawn(10'd11, 9'd200);
    spawn(10'd12, 9'd200);
    i_Tick = 1'b1;
    spawn(10'd13, 9'd200);
    i_Tick = 1'b0;
    n_total++; if (o_SpawnAck !== 1'b1 || o_Count !== 5'd3) $display("FAIL st_ack got ack=%b c=%0d exp ack=1 c=3", o_SpawnAck, o_Count); else n_pass++;
    n_total++; if (slot(2) !== {10'd13, 9'd200}) $display("FAIL st_new got %h exp %h", slot(2), {10'd13, 9'd200}); else n_pass++;
    n_total++; if (slot(0) !== {10'd11, 9'd199} || slot(1) !== {10'd12, 9'd199}) $display("FAIL st_old got %h %h exp %h %h", slot(0), slot(1), {10'd11, 9'd199}, {10'd12, 9'd199}); else n_pass++;
  endtask

  task automatic test_bounds_clear();
    do_clear();
    for (int i = 0; i < 4; i++) spawn(10'd50, 9'd100);
    spawn(10'd60, 9'd479);
    n_total++; if (o_SpawnAck !== 1'b1 || slot(4) !== {10'd60, 9'd479}) $display("FAIL ymax_ok got ack=%b pos=%h exp ack=1 pos=%h", o_SpawnAck, slot(4), {10'd60, 9'd479}); else n_pass++;
    spawn(10'd60, 9'd480);
    n_total++; if (o_SpawnDrop !== 1'b1 || o_SpawnAck !== 1'b0) $display("FAIL ymax_drop got ack=%b drop=%b exp ack=0 drop=1", o_SpawnAck, o_SpawnDrop); else n_pass++;
    n_total++; if (o_Alive !== 16'h001F || o_Count !== 5'd5) $display("FAIL ymax_state got %h c=%0d exp 001f c=5", o_Alive, o_Count); else n_pass++;
    i_SpawnReq = 1'b1; i_SpawnPos = {10'd1, 9'd100};
    do_clear();
    i_SpawnReq = 1'b0;
    n_total++; if (o_Alive !== 16'h0000 || o_Count !== 5'd0 || o_Empty !== 1'b1) $display("FAIL clear_state got %h c=%0d e=%b exp 0000 c=0 e=1", o_Alive, o_Count, o_Empty); else n_pass++;
    n_total++; if (o_SpawnDrop !== 1'b1 || o_SpawnAck !== 1'b0) $display("FAIL clear_drop got ack=%b drop=%b exp ack=0 drop=1", o_SpawnAck, o_SpawnDrop); else n_pass++;
    n_total++; if (slot(4) !== 19'h7FFFF) $display("FAIL clear_pos got %h exp 7ffff", slot(4)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_spawn3();
    test_move_retire();
    test_full();
    test_kill_spawn();
    test_spawn_tick();
    test_bounds_clear();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
